// File: rtl/printf_dec_pkg.sv
// printf_dec_pkg: shared FSM states, ASCII constants and widths for the trace line decoder.
package printf_dec_pkg;
    typedef enum logic [3:0] {
        S_HDR, S_PAD, S_DEC, S_IO, S_X, S_SP, S_Y, S_EOL, S_HOLD, S_RESYNC
    } state_t;
    localparam int DEF_CYC_W = 32;
    localparam int ERR_CNT_W = 16;
    localparam logic [7:0] CH_UC = 8'h43;
    localparam logic [7:0] CH_Y = 8'h79;
    localparam logic [7:0] CH_LC = 8'h63;
    localparam logic [7:0] CH_EQ = 8'h3d;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_O = 8'h6f;
    localparam logic [7:0] CH_COL = 8'h3a;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;
    function automatic logic [7:0] hdr_char(input logic [1:0] i);
        return i == 2'd0 ? CH_UC : i == 2'd1 ? CH_Y : i == 2'd2 ? CH_LC : CH_EQ;
    endfunction
    function automatic logic [7:0] io_char(input logic [1:0] i);
        return i == 2'd0 ? CH_I : i == 2'd1 ? CH_O : i == 2'd2 ? CH_COL : CH_SP;
    endfunction
endpackage

// File: rtl/printf_line_decoder_if.sv
// printf_line_decoder_if: byte-in / record-out handshake bundle of the trace line decoder.
interface printf_line_decoder_if import printf_dec_pkg::*; #(parameter int CYC_W = DEF_CYC_W);
    logic in_valid;
    logic in_ready;
    logic [7:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [CYC_W-1:0] out_cyc;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic err;
    logic [ERR_CNT_W-1:0] err_cnt;
    modport master (output in_valid, in_data, out_ready,
                    input in_ready, out_valid, out_cyc, out_x, out_y, err, err_cnt);
    modport slave (input in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_cyc, out_x, out_y, err, err_cnt);
endinterface

// File: rtl/printf_dec_char.sv
// printf_dec_char: combinational ASCII classifier returning digit class flags and nibble value.
module printf_dec_char (
    input  logic [7:0] c,
    output logic       is_dec,
    output logic       is_hex,
    output logic       is_space,
    output logic       is_lf,
    output logic       is_cr,
    output logic [3:0] nib
);
    import printf_dec_pkg::*;
    logic is_lo, is_up;
    assign is_dec = c >= 8'h30 && c <= 8'h39;
    assign is_lo = c >= 8'h61 && c <= 8'h66;
    assign is_up = c >= 8'h41 && c <= 8'h46;
    assign is_hex = is_dec || is_lo || is_up;
    assign is_space = c == CH_SP;
    assign is_lf = c == CH_LF;
    assign is_cr = c == CH_CR;
    // 'a'/'A' low nibble is 1, so letters map to low nibble + 9
    assign nib = is_dec ? c[3:0] : c[3:0] + 4'd9;
endmodule

// File: rtl/printf_line_decoder.sv
// printf_line_decoder: decodes "Cyc= <dec> io: <hex2> <hex2>\n" trace lines into binary records.
// Define PRINTF_DEC_ERRCNT_EN to build the saturating malformed-line counter; otherwise err_cnt is 0.
module printf_line_decoder import printf_dec_pkg::*; #(
    parameter int CYC_W = DEF_CYC_W
) (
    input logic clk,
    input logic reset_n,
    printf_line_decoder_if.slave bus
);
    state_t state;
    logic [4:0] idx;
    logic [CYC_W-1:0] acc;
    logic [7:0] x, y;
    logic [7:0] c;
    logic is_dec, is_hex, is_space, is_lf, is_cr, fire, ok, ovf;
    logic [3:0] nib;
    logic [CYC_W+3:0] acc_next;

    printf_dec_char u_char (
        .c(c), .is_dec(is_dec), .is_hex(is_hex), .is_space(is_space),
        .is_lf(is_lf), .is_cr(is_cr), .nib(nib)
    );

    assign c = bus.in_data;
    assign bus.in_ready = state != S_HOLD;
    assign fire = bus.in_valid && bus.in_ready;
    // acc*10 + digit with 4 guard bits to catch overflow past CYC_W
    assign acc_next = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{CYC_W{1'b0}}, nib};
    assign ovf = |acc_next[CYC_W+3:CYC_W];

    always_comb begin
        ok = 1'b1;
        case (state)
            S_HDR: ok = c == hdr_char(idx[1:0]);
            S_PAD: ok = is_space || is_dec;
            S_DEC: ok = is_space || (is_dec && !ovf && idx < 5'd20);
            S_IO: ok = c == io_char(idx[1:0]);
            S_X, S_Y: ok = is_hex;
            S_SP: ok = is_space;
            S_EOL: ok = is_cr || is_lf;
            default: ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_HDR;
            idx <= '0;
            acc <= '0;
            x <= '0;
            y <= '0;
            bus.out_valid <= 1'b0;
            bus.out_cyc <= '0;
            bus.out_x <= '0;
            bus.out_y <= '0;
            bus.err <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                state <= S_HDR;
                acc <= '0;
                idx <= '0;
            end else if (fire && !ok) begin
                bus.err <= 1'b1;
                state <= is_lf ? S_HDR : S_RESYNC;
                acc <= '0;
                idx <= '0;
            end else if (fire) begin
                case (state)
                    S_HDR: begin
                        idx <= idx == 5'd3 ? 5'd0 : idx + 5'd1;
                        if (idx == 5'd3) state <= S_PAD;
                    end
                    S_PAD: if (is_dec) begin
                        state <= S_DEC;
                        acc <= {{(CYC_W-4){1'b0}}, nib};
                        idx <= 5'd1;
                    end
                    S_DEC: if (is_space) begin
                        state <= S_IO;
                        idx <= '0;
                    end else begin
                        acc <= acc_next[CYC_W-1:0];
                        idx <= idx + 5'd1;
                    end
                    S_IO: begin
                        idx <= idx == 5'd3 ? 5'd0 : idx + 5'd1;
                        if (idx == 5'd3) state <= S_X;
                    end
                    S_X: begin
                        x <= {x[3:0], nib};
                        idx <= idx == 5'd1 ? 5'd0 : idx + 5'd1;
                        if (idx == 5'd1) state <= S_SP;
                    end
                    S_SP: state <= S_Y;
                    S_Y: begin
                        y <= {y[3:0], nib};
                        idx <= idx == 5'd1 ? 5'd0 : idx + 5'd1;
                        if (idx == 5'd1) state <= S_EOL;
                    end
                    S_EOL: if (is_lf) begin
                        state <= S_HOLD;
                        bus.out_valid <= 1'b1;
                        bus.out_cyc <= acc;
                        bus.out_x <= x;
                        bus.out_y <= y;
                    end
                    S_RESYNC: if (is_lf) state <= S_HDR;
                    default: ;
                endcase
            end
        end
    end

`ifdef PRINTF_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.err_cnt <= '0;
        else if (bus.err && bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
    end
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_printf_line_decoder.sv
// tb_printf_line_decoder: directed byte-stream checks of the trace line decoder.
module tb_printf_line_decoder;
    import printf_dec_pkg::*;
    logic clk;
    logic reset_n;
    int checks;
    int errors;
    int err_pulses;
    int e0;

    printf_line_decoder_if #(.CYC_W(32)) bus ();
    printf_line_decoder #(.CYC_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.err) err_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input logic [31:0] cyc, input logic [7:0] x, input logic [7:0] y);
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_cyc"}, {32'd0, bus.out_cyc}, {32'd0, cyc});
        chk({tag, "_xy"}, {48'd0, bus.out_x, bus.out_y}, {48'd0, x, y});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        err_pulses = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.in_ready, bus.out_valid, bus.out_cyc, bus.out_x, bus.out_y, bus.err},
            {1'b1, 1'b0, 32'd0, 8'd0, 8'd0, 1'b0});
        chk("reset_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        send_str("Cyc=          5 io: 0a ff\n");
        chk_rec("padded", 32'd5, 8'h0a, 8'hff);
        chk("padded_no_err", err_pulses, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("backpressure_hold", {bus.in_ready, bus.out_valid, bus.out_cyc, bus.out_x, bus.out_y},
                {1'b0, 1'b1, 32'd5, 8'h0a, 8'hff});
        end
        take();
        chk("after_take", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});

        send_str("Cyc=4294967295 io: 00 01\n");
        chk_rec("max", 32'hffffffff, 8'h00, 8'h01);
        take();

        e0 = err_pulses;
        send_str("Cyc=429496729");
        chk("pre_ovf_no_err", {63'd0, bus.err}, 64'd0);
        send_byte("6");
        chk("ovf_err", {63'd0, bus.err}, 64'd1);
        send_str(" io: 00 01\n");
        chk("ovf_no_rec", {63'd0, bus.out_valid}, 64'd0);
        chk("ovf_one_pulse", err_pulses, e0 + 1);
`ifdef PRINTF_DEC_ERRCNT_EN
        chk("ovf_err_cnt", {48'd0, bus.err_cnt}, 64'd1);
`else
        chk("ovf_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
`endif

        send_str("Cyc= 7 io: AB cD");
        send_byte(8'h0d);
        send_byte(8'h0a);
        chk_rec("crlf", 32'd7, 8'hab, 8'hcd);
        take();

        e0 = err_pulses;
        send_str("Cyc= 1 io: 0");
        send_byte("g");
        chk("badhex_err", {63'd0, bus.err}, 64'd1);
        send_str(" 00\n");
        chk("badhex_no_rec", {63'd0, bus.out_valid}, 64'd0);
        chk("badhex_one_pulse", err_pulses, e0 + 1);
        send_str("Cyc= 2 io: 11 22\n");
        chk_rec("after_bad", 32'd2, 8'h11, 8'h22);
        take();

        send_str("Cyc= 12");
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_outs", {bus.in_ready, bus.out_valid, bus.out_cyc, bus.out_x, bus.out_y, bus.err},
            {1'b1, 1'b0, 32'd0, 8'd0, 8'd0, 1'b0});
        chk("midreset_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        e0 = err_pulses;
        send_byte(" ");
        chk("remainder_err", {63'd0, bus.err}, 64'd1);
        send_str("io: 01 02\n");
        chk("remainder_no_rec", {63'd0, bus.out_valid}, 64'd0);
        chk("remainder_one_pulse", err_pulses, e0 + 1);
        send_str("Cyc= 3 io: 04 05\n");
        chk_rec("after_reset", 32'd3, 8'h04, 8'h05);
`ifdef PRINTF_DEC_ERRCNT_EN
        chk("final_err_cnt", {48'd0, bus.err_cnt}, 64'd1);
`else
        chk("final_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
`endif
        take();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/printf_line_decoder.md
# printf_line_decoder

Receive-side counterpart of the simulation printf trace formatter. Accepts an ASCII byte stream of trace lines of the form `Cyc= <decimal> io: <hex2> <hex2>` terminated by LF. Decodes each line back into a binary record: cycle stamp plus two 8-bit I/O values. Sits between a trace byte source (UART/DPI bridge or replay buffer) and the on-chip checker that compares replayed traces against live I/O.

## Interface

Parameters:
- CYC_W, 32, width of decoded cycle stamp; maximum legal value 2^CYC_W−1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte source has a byte.
- in_ready  out  1  decoder accepts the byte this cycle.
- in_data  in  8  ASCII byte.
- out_valid  out  1  decoded record available.
- out_ready  in  1  consumer takes the record.
- out_cyc  out  CYC_W  decoded cycle stamp.
- out_x  out  8  first hex field.
- out_y  out  8  second hex field.
- err  out  1  one-cycle pulse on the first malformed byte of a line.
- err_cnt  out  16  saturating malformed-line count; see Configuration.

## Operation

- Byte transfer occurs when in_valid && in_ready.
- FSM states and transitions:
  - HDR: match literal `Cyc=` in order.
  - PAD: skip 0x20; the first digit moves to DEC.
  - DEC: digits accumulate; 0x20 moves to IO.
  - IO: match `io:` then one 0x20.
  - X: exactly two hex digits.
  - SP: one 0x20.
  - Y: exactly two hex digits.
  - EOL: 0x0D ignored; 0x0A moves to HOLD.
  - HOLD: output valid.
  - RESYNC: discard bytes until 0x0A, then go to HDR.
- Decimal arithmetic: acc_next = (acc<<3) + (acc<<1) + digit, computed in CYC_W+4 bits.
  - Any nonzero bit above CYC_W−1 is overflow, which is an error.
  - DEC with zero digits, or more than 20 digits, is an error.
- Hex digits: 0-9, a-f and A-F are accepted. `x`, `z` or any other byte is an error.
- Error handling: any byte not legal in the current state pulses err for one cycle and enters RESYNC. A 0x0A arriving as the error byte goes directly to HDR.
- HOLD:
  - in_ready=0.
  - out_* are held stable until out_ready.
  - On handshake, the FSM goes to HDR and the accumulator clears.
- in_ready=1 in every state except HOLD.

## Timing

- Reset values:
  - in_ready=1, out_valid=0, out_cyc=0, out_x=0, out_y=0, err=0, err_cnt=0.
  - FSM in HDR.
- Latency: LF accepted at cycle N gives out_valid=1 at N+1, with out_* registered.
- Throughput: one byte per cycle. Zero bubble after the record handshake; the next byte is accepted the cycle after the handshake.
- err asserts in the cycle after the offending byte is accepted.
- reset_n assertion mid-line discards the partial line immediately. The stream then resumes in HDR, so any remainder of that line produces err and RESYNC.
- Boundary behaviour:
  - Value 2^CYC_W−1 is legal.
  - 2^CYC_W is an error on the digit that overflows.
  - err_cnt saturates at 0xFFFF.

## Configuration

- PRINTF_DEC_ERRCNT_EN defined:
  - err_cnt increments once per err pulse and saturates.
- PRINTF_DEC_ERRCNT_EN undefined:
  - The counter logic is compiled out and err_cnt is tied to 0.
  - err is unaffected.

## Structure

- Shared package printf_dec_pkg:
  - FSM state enum.
  - ASCII constants: C, y, c, =, i, o, :, space, CR, LF.
  - Default CYC_W.
  - Error counter width.
- Sub-module printf_dec_char, combinational:
  - Classifies a byte as is_dec, is_hex, is_space, is_lf or is_cr.
  - Returns its 4-bit nibble value.
- Top holds the FSM, the accumulator, the X/Y nibble registers and the output registers.

## Test plan

- Padded stamp: `Cyc=          5 io: 0a ff\n` → one cycle after LF, out_valid=1 with out_cyc=5, out_x=0x0A, out_y=0xFF. No err.
- Width boundary, legal: `Cyc=4294967295 io: 00 01\n` → out_cyc=0xFFFFFFFF.
- Width boundary, overflow: `Cyc=4294967296 io: 00 01\n` → err pulse after the final `6`, no record, err_cnt=1 (with the macro enabled).
- Backpressure: out_ready low for 5 cycles after a record → in_ready=0 and out_* stable throughout. Then `Cyc= 7 io: AB cD\r\n` → out_cyc=7, out_x=0xAB, out_y=0xCD.
- Bad hex: `Cyc= 1 io: 0g 00\n Cyc= 2 io: 11 22\n` → err on `g`, first line dropped. Second line decodes to out_cyc=2, out_x=0x11, out_y=0x22.
- Reset mid-line: reset_n low after `Cyc= 12`, remainder ` io: 01 02\n` then `Cyc= 3 io: 04 05\n`:
  - During reset, all outputs are 0.
  - After release, err pulses once on the leading space and the remainder is discarded.
  - The next line gives out_cyc=3, out_x=0x04, out_y=0x05.
